// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO bus controller.
// FSM state encoding, IO register offsets and the default IO window.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] IO_LED  = 2'd0;
  localparam logic [1:0] IO_SW   = 2'd1;
  localparam logic [1:0] IO_TMR  = 2'd2;
  localparam logic [1:0] IO_STAT = 2'd3;

  localparam logic [3:0] IO_BASE_DEF = 4'hF;

endpackage

// File: rtl/mio_timer.sv
// Reloading down-counter with a sticky interrupt flag.
// A zero reload value disables the timer.
module mio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  input  logic        clr,
  output logic        irq
);

  logic [31:0] reload;
  logic        uf;

  // a CPU load suppresses the underflow in the same cycle
  assign uf = !wr && (reload != '0) && (count == 32'd1);

  // reload/count update and irq set-over-clear priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload <= '0;
      count  <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr) begin
        reload <= wdata;
        count  <= wdata;
      end else if (reload != '0) begin
        if (count == 32'd1) count <= reload;
        else                count <= count - 32'd1;
      end
      if (uf)       irq <= 1'b1;
      else if (clr) irq <= 1'b0;
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU memory-port bus controller: routes requests to block RAM
// or to LED/switch/timer registers and returns a ready pulse.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int         RAM_AW  = 10,
  parameter int         RAM_LAT = 2,
  parameter logic [3:0] IO_BASE = IO_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_we,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic              irq
);

  localparam logic [2:0] LAT_M1 = 3'(RAM_LAT - 1);

  state_t      state, state_nx;
  logic        is_io, take, we_q;
  logic [1:0]  ofs;
  logic [2:0]  wcnt;
  logic [15:0] sw_m, sw_s;
  logic [31:0] io_rdata, tmr_count;
  logic        tmr_wr, tmr_clr;
  logic        unused_addr;

  assign is_io = cpu_addr[31:28] == IO_BASE;
  assign take  = (state == IDLE) && cpu_req;
  assign ofs   = cpu_addr[3:2];

  assign tmr_wr  = take && is_io && cpu_we && (ofs == IO_TMR);
  assign tmr_clr = take && is_io && cpu_we && (ofs == IO_STAT)
                   && cpu_wdata[0];

  assign unused_addr = ^{cpu_addr[27:RAM_AW+2], cpu_addr[1:0]};

  mio_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .wr    (tmr_wr),
    .wdata (cpu_wdata),
    .count (tmr_count),
    .clr   (tmr_clr),
    .irq   (irq)
  );

  // IO read mux, indexed by word offset within the IO window
  always_comb begin
    io_rdata = '0;
    unique case (ofs)
      IO_LED:  io_rdata = {16'b0, led_out};
      IO_SW:   io_rdata = {16'b0, sw_s};
      IO_TMR:  io_rdata = tmr_count;
      IO_STAT: io_rdata = {31'b0, irq};
      default: io_rdata = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state: writes leave RAM_WAIT after one cycle, reads after RAM_LAT
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (cpu_req) state_nx = is_io ? DONE : RAM_WAIT;
      RAM_WAIT: if (we_q || wcnt == LAT_M1) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // outputs: RAM strobe in the accepting cycle, ready while in DONE
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_ready = 1'b0;
    if (!reset) begin
      if (take && !is_io) begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr[RAM_AW+1:2];
        ram_wdata = cpu_wdata;
      end
      cpu_ready = state == DONE;
    end
  end

  // request latch, wait counter, IO registers and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      wcnt      <= '0;
      led_out   <= '0;
      cpu_rdata <= '0;
    end else if (take) begin
      we_q <= cpu_we;
      wcnt <= '0;
      if (is_io && cpu_we && ofs == IO_LED) led_out <= cpu_wdata[15:0];
      if (is_io && !cpu_we) cpu_rdata <= io_rdata;
    end else if (state == RAM_WAIT) begin
      wcnt <= wcnt + 3'd1;
      if (!we_q && wcnt == LAT_M1) cpu_rdata <= ram_rdata;
    end
  end

  // two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sw_in;
      sw_s <= sw_m;
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl with a latency-accurate RAM model.
// Latency is counted inclusively: sample cycle through ready cycle.
module tb_mio_bus_ctrl;

  localparam int L = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [31:0] data;
    int          lat;
    int          t0;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int rdy_cnt = 0;

  sb_t        exp_q[$];
  sb_t        e;
  logic [9:0] wr_log[$];
  vec_t       tbl[12];
  vec_t       seq[6];

  logic [31:0] mem [0:1023];
  logic [31:0] pd [1:8];
  logic        pv [1:8];

  mio_bus_ctrl #(
    .RAM_AW  (10),
    .RAM_LAT (L),
    .IO_BASE (4'hF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data for an enable in cycle k is valid only in cycle k+L
  assign ram_rdata = pv[L+1] ? pd[L+1] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 1; i <= 8; i++) pv[i] <= 1'b0;
    end else begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      pv[1] <= ram_en && !ram_we;
      pd[1] <= mem[ram_addr];
      for (int i = 2; i <= 8; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  task automatic chk32(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard: pop one expectation per ready pulse
  always @(negedge clk) begin
    if (ram_en) begin
      en_cnt++;
      if (ram_we) wr_log.push_back(ram_addr);
    end
    if (cpu_ready) begin
      rdy_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready got 1 want 0 cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk32("latency", cyc - e.t0 + 1, e.lat);
        if (e.chk) chk32("rdata", cpu_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v, input bit hold);
    sb_t s;
    s.chk  = !v.we;
    s.data = v.rdata;
    s.lat  = v.lat;
    s.t0   = cyc;
    exp_q.push_back(s);
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_we    = v.we;
    cpu_req   = 1'b1;
    step();
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic wait_ready(input bit drop);
    int n = 0;
    while (!cpu_ready && n < 30) begin
      step();
      n++;
    end
    if (!cpu_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got none want ready in 30 cycles");
      exp_q.delete();
    end
    if (drop) cpu_req = 1'b0;
    step();
  endtask

  task automatic xact(input vec_t v);
    issue(v, 1'b0);
    wait_ready(1'b1);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w,
                              input logic we, input logic [31:0] r,
                              input int lat);
    vec_t v;
    v.addr = a; v.wdata = w; v.we = we; v.rdata = r; v.lat = lat;
    return v;
  endfunction

  initial begin
    int e0, r0, hi;
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_we = 1'b0; sw_in = 16'h3C5A;

    tbl[0]  = mk(32'h0000_0010, 32'h1234_5678, 1'b1, 32'h0, 3);
    tbl[1]  = mk(32'h0000_0010, 32'h0, 1'b0, 32'h1234_5678, L+2);
    tbl[2]  = mk(32'hF000_0000, 32'h0000_A5A5, 1'b1, 32'h0, 2);
    tbl[3]  = mk(32'hF000_0000, 32'h0, 1'b0, 32'h0000_A5A5, 2);
    tbl[4]  = mk(32'hF000_0004, 32'hFFFF_FFFF, 1'b1, 32'h0, 2);
    tbl[5]  = mk(32'hF000_0004, 32'h0, 1'b0, 32'h0000_3C5A, 2);
    tbl[6]  = mk(32'h0000_0FFC, 32'hCAFE_F00D, 1'b1, 32'h0, 3);
    tbl[7]  = mk(32'h0000_0FFE, 32'h0, 1'b0, 32'hCAFE_F00D, L+2);
    tbl[8]  = mk(32'h0000_0013, 32'h0, 1'b0, 32'h1234_5678, L+2);
    tbl[9]  = mk(32'hF000_0003, 32'h0, 1'b0, 32'h0000_A5A5, 2);
    tbl[10] = mk(32'hF000_000C, 32'h0, 1'b0, 32'h0, 2);
    tbl[11] = mk(32'hE000_0010, 32'h0, 1'b0, 32'h1234_5678, L+2);

    seq[0] = mk(32'h0000_0010, 32'h0, 1'b0, 32'h1234_5678, L+2);
    seq[1] = mk(32'hF000_0000, 32'h0, 1'b0, 32'h0000_A5A5, 2);
    seq[2] = mk(32'h0000_0040, 32'h0000_0055, 1'b1, 32'h0, 3);
    seq[3] = mk(32'hF000_0000, 32'h0000_1111, 1'b1, 32'h0, 2);
    seq[4] = mk(32'h0000_0040, 32'h0, 1'b0, 32'h0000_0055, L+2);
    seq[5] = mk(32'hF000_0000, 32'h0, 1'b0, 32'h0000_1111, 2);

    repeat (3) step();
    chk32("rst_rdata", cpu_rdata, 32'h0);
    chk32("rst_led", {16'h0, led_out}, 32'h0);
    chk32("rst_ctl", {28'h0, cpu_ready, ram_en, ram_we, irq}, 32'h0);
    chk32("rst_ram", ram_wdata | {22'h0, ram_addr}, 32'h0);
    reset = 1'b0;
    repeat (3) step();

    foreach (tbl[i]) xact(tbl[i]);
    chk32("led_value", {16'h0, led_out}, 32'h0000_A5A5);
    chk32("ram_we_pulses", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk32("ram_addr_w0", {22'h0, wr_log[0]}, 32'd4);
      chk32("ram_addr_w1", {22'h0, wr_log[1]}, 32'd1023);
    end

    xact(mk(32'h0000_0020, 32'h0000_0077, 1'b1, 32'h0, 3));
    xact(mk(32'hF000_000C, 32'h0, 1'b1, 32'h0, 2));
    chk32("rdata_hold", cpu_rdata, 32'h1234_5678);

    issue(mk(32'hF000_0008, 32'd3, 1'b1, 32'h0, 2), 1'b0);
    step();
    chk32("irq_e2", {31'h0, irq}, 32'h0);
    issue(mk(32'hF000_0008, 32'h0, 1'b0, 32'd2, 2), 1'b0);
    chk32("irq_e3", {31'h0, irq}, 32'h0);
    step();
    chk32("irq_rise", {31'h0, irq}, 32'h1);
    issue(mk(32'hF000_0008, 32'h0, 1'b0, 32'd3, 2), 1'b0);
    step();
    issue(mk(32'hF000_000C, 32'h1, 1'b1, 32'h0, 2), 1'b0);
    chk32("irq_set_wins", {31'h0, irq}, 32'h1);
    step();
    issue(mk(32'hF000_000C, 32'h1, 1'b1, 32'h0, 2), 1'b0);
    chk32("irq_clear", {31'h0, irq}, 32'h0);
    step();
    chk32("irq_again", {31'h0, irq}, 32'h1);
    issue(mk(32'hF000_000C, 32'h0, 1'b0, 32'h1, 2), 1'b0);
    step();
    issue(mk(32'hF000_0008, 32'h0, 1'b1, 32'h0, 2), 1'b0);
    step();
    issue(mk(32'hF000_000C, 32'h1, 1'b1, 32'h0, 2), 1'b0);
    step();
    hi = 0;
    repeat (20) begin
      if (irq) hi++;
      step();
    end
    chk32("irq_disabled", hi, 0);
    xact(mk(32'hF000_0008, 32'h0, 1'b0, 32'h0, 2));

    e0 = en_cnt;
    r0 = rdy_cnt;
    foreach (seq[i]) begin
      issue(seq[i], 1'b1);
      wait_ready(i == 5);
    end
    chk32("held_ram_en", en_cnt - e0, 3);
    chk32("held_ready", rdy_cnt - r0, 6);

    cpu_addr = 32'h0000_0010; cpu_we = 1'b0; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    reset = 1'b1;
    #1;
    chk32("arst_rdata", cpu_rdata, 32'h0);
    chk32("arst_led", {16'h0, led_out}, 32'h0);
    chk32("arst_ctl", {28'h0, cpu_ready, ram_en, ram_we, irq}, 32'h0);
    step();
    step();
    reset = 1'b0;
    r0 = rdy_cnt;
    repeat (10) step();
    chk32("no_ready_after_rst", rdy_cnt - r0, 0);
    xact(mk(32'h0000_0010, 32'h0, 1'b0, 32'h1234_5678, L+2));

    repeat (3) step();
    chk32("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
